// File: rtl/util_mw_adc_bridge_pack.sv
// util_mw_adc_bridge_pack: registers ADC data toward the user IP and packs its enabled return lanes into DMA words.
// Defining MW_ADC_BRIDGE_WORD_COUNT_EN adds the 32-bit dmac_word_count output.
module util_mw_adc_bridge_pack #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHAN = 4
) (
  input  logic                           adc_clk,
  input  logic                           adc_rst,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] adc_data,
  input  logic [NUM_CHAN-1:0]            adc_valid,
  input  logic [NUM_CHAN-1:0]            adc_enable,
  output logic [NUM_CHAN*DATA_WIDTH-1:0] bridge_out,
  output logic                           bridge_out_valid,
  output logic                           bridge_out_enable,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] bridge_in,
  input  logic                           bridge_in_valid,
  output logic [NUM_CHAN*DATA_WIDTH-1:0] dmac_data,
  output logic                           dmac_valid,
  input  logic                           dmac_ovf,
`ifdef MW_ADC_BRIDGE_WORD_COUNT_EN
  output logic [31:0]                    dmac_word_count,
`endif
  output logic                           ovf_flag
);
  localparam int W = NUM_CHAN*DATA_WIDTH;
  localparam int CW = NUM_CHAN > 1 ? $clog2(NUM_CHAN) : 1;
  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] bo_q, bo_d, slot, merged, acc_q, acc_d, data_q, data_d;
  logic bov_q, bov_d, boe_q, boe_d, ovf_q, ovf_d, emit, pow2, changed, take;
  logic [NUM_CHAN-1:0] en_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  int e, base;
  // Compact the enabled channels of bridge_in into the low lanes of a slot.
  always_comb begin
    slot = '0;
    e = 0;
    for (int c = 0; c < NUM_CHAN; c++)
      if (adc_enable[c]) begin
        slot[e*DATA_WIDTH +: DATA_WIDTH] = bridge_in[c*DATA_WIDTH +: DATA_WIDTH];
        e = e + 1;
      end
  end
  // A mask change restarts accumulation; a beat in that cycle becomes slot 0.
  always_comb begin
    bo_d = adc_data;
    bov_d = |adc_valid;
    boe_d = |adc_enable;
    ovf_d = ovf_q | dmac_ovf;
    changed = adc_enable != en_prev_q;
    pow2 = e != 0 && (e & (e - 1)) == 0;
    base = changed ? 0 : int'(cnt_q);
    merged = changed ? '0 : acc_q;
    for (int l = 0; l < NUM_CHAN; l++)
      if (l < e && base*e + l < NUM_CHAN)
        merged[(base*e + l)*DATA_WIDTH +: DATA_WIDTH] = slot[l*DATA_WIDTH +: DATA_WIDTH];
    emit = bridge_in_valid && e != 0 && (!pow2 || (base + 1)*e == NUM_CHAN);
    take = bridge_in_valid && pow2 && !emit;
    acc_d = take ? merged : (changed || emit) ? '0 : acc_q;
    cnt_d = take ? CW'(base + 1) : (changed || emit) ? '0 : cnt_q;
    data_d = !emit ? data_q : pow2 ? merged : slot;
  end
  always_comb state_d = emit ? EMIT : (e == 0) ? IDLE : FILL;
  always_comb dmac_valid = state_q == EMIT;
  always_ff @(posedge adc_clk or posedge adc_rst)
    if (adc_rst) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge adc_clk or posedge adc_rst)
    if (adc_rst) begin
      bo_q <= '0;
      bov_q <= 1'b0;
      boe_q <= 1'b0;
      ovf_q <= 1'b0;
      en_prev_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      bo_q <= bo_d;
      bov_q <= bov_d;
      boe_q <= boe_d;
      ovf_q <= ovf_d;
      en_prev_q <= adc_enable;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
  assign bridge_out = bo_q;
  assign bridge_out_valid = bov_q;
  assign bridge_out_enable = boe_q;
  assign dmac_data = data_q;
  assign ovf_flag = ovf_q;
`ifdef MW_ADC_BRIDGE_WORD_COUNT_EN
  logic [31:0] wc_q, wc_d;
  always_comb wc_d = emit ? wc_q + 32'd1 : wc_q;
  always_ff @(posedge adc_clk or posedge adc_rst)
    if (adc_rst) wc_q <= '0;
    else wc_q <= wc_d;
  assign dmac_word_count = wc_q;
`endif
endmodule

// File: tb/tb_util_mw_adc_bridge_pack.sv
// tb_util_mw_adc_bridge_pack: vector table plus reset/overflow sequences, packed words checked against a queue.
module tb_util_mw_adc_bridge_pack;
  localparam int DW = 16, NC = 4, W = DW*NC;
  logic adc_clk = 1'b0, adc_rst = 1'b1;
  logic [W-1:0] adc_data = '0, bridge_in = '0;
  logic [NC-1:0] adc_valid = '0, adc_enable = '0;
  logic bridge_in_valid = 1'b0, dmac_ovf = 1'b0;
  logic [W-1:0] bridge_out, dmac_data;
  logic bridge_out_valid, bridge_out_enable, dmac_valid, ovf_flag;
`ifdef MW_ADC_BRIDGE_WORD_COUNT_EN
  logic [31:0] dmac_word_count;
`endif
  util_mw_adc_bridge_pack #(.DATA_WIDTH(DW), .NUM_CHAN(NC)) dut (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .adc_enable(adc_enable), .bridge_out(bridge_out), .bridge_out_valid(bridge_out_valid),
    .bridge_out_enable(bridge_out_enable), .bridge_in(bridge_in), .bridge_in_valid(bridge_in_valid),
    .dmac_data(dmac_data), .dmac_valid(dmac_valid), .dmac_ovf(dmac_ovf),
`ifdef MW_ADC_BRIDGE_WORD_COUNT_EN
    .dmac_word_count(dmac_word_count),
`endif
    .ovf_flag(ovf_flag));
  always #5 adc_clk = ~adc_clk;
  typedef struct {
    logic [NC-1:0] en;
    logic [W-1:0] bin;
    logic bv;
    logic push;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [W-1:0] q[$];
  logic [W-1:0] last_data = '0;
  int checks = 0, errors = 0;
  function automatic logic [W-1:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask
  task automatic add(input logic [NC-1:0] en, input logic [W-1:0] bin, input logic bv, input logic push, input logic [W-1:0] exp);
    vec_t v;
    v.en = en; v.bin = bin; v.bv = bv; v.push = push; v.exp = exp;
    tbl.push_back(v);
  endtask
  task automatic step(input logic [NC-1:0] en, input logic [W-1:0] bin, input logic bv, input logic push, input logic [W-1:0] exp);
    logic [W-1:0] d;
    logic [NC-1:0] av;
    d = W'({$urandom, $urandom});
    av = NC'($urandom);
    adc_data = d; adc_valid = av; adc_enable = en; bridge_in = bin; bridge_in_valid = bv;
    if (push) q.push_back(exp);
    @(posedge adc_clk); #1;
    chk("bridge_out", bridge_out, d);
    chk("bridge_out_valid", W'(bridge_out_valid), W'(|av));
    chk("bridge_out_enable", W'(bridge_out_enable), W'(|en));
  endtask
  task automatic do_reset();
    adc_rst = 1'b1;
    adc_enable = '0; bridge_in_valid = 1'b0; dmac_ovf = 1'b0; adc_valid = '0;
    last_data = '0;
    #1;
    chk("rst_bridge_out", bridge_out, '0);
    chk("rst_flags", W'({bridge_out_valid, bridge_out_enable, dmac_valid, ovf_flag}), '0);
    chk("rst_dmac_data", dmac_data, '0);
    @(posedge adc_clk); #1;
    adc_rst = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge adc_clk);
    #1;
    chk("queue_drained", W'(q.size()), '0);
  endtask
  always @(negedge adc_clk)
    if (!adc_rst) begin
      if (dmac_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %h exp none", dmac_data);
        end else begin
          last_data = q.pop_front();
          chk("dmac_data", dmac_data, last_data);
        end
      end else chk("dmac_hold", dmac_data, last_data);
    end
  initial begin
    add(4'hF, pk(4, 3, 2, 1), 1, 1, pk(4, 3, 2, 1));
    add(4'hF, pk(8, 7, 6, 5), 1, 1, pk(8, 7, 6, 5));
    add(4'h5, pk('hDEAD, 'hA2, 'hBEEF, 'hA0), 1, 0, '0);
    add(4'h5, pk('hDEAD, 'hB2, 'hBEEF, 'hB0), 1, 1, pk('hB2, 'hB0, 'hA2, 'hA0));
    add(4'h5, pk(1, 'hC2, 3, 'hC0), 1, 0, '0);
    add(4'h5, pk(1, 'h99, 3, 'h98), 0, 0, '0);
    add(4'h5, pk(1, 'hD2, 3, 'hD0), 1, 1, pk('hD2, 'hD0, 'hC2, 'hC0));
    add(4'h7, pk('h9999, 3, 2, 1), 1, 1, pk(0, 3, 2, 1));
    add(4'h7, pk('h9999, 6, 5, 4), 1, 1, pk(0, 6, 5, 4));
    add(4'h1, pk(7, 7, 7, 'h11), 1, 0, '0);
    add(4'h1, pk(7, 7, 7, 'h12), 1, 0, '0);
    add(4'h3, pk(7, 7, 7, 7), 0, 0, '0);
    add(4'h3, pk(7, 7, 'h22, 'h21), 1, 0, '0);
    add(4'h3, pk(7, 7, 'h32, 'h31), 1, 1, pk('h32, 'h31, 'h22, 'h21));
    add(4'h0, pk(1, 2, 3, 4), 1, 0, '0);
    add(4'h0, pk(1, 2, 3, 4), 1, 0, '0);
    add(4'h2, pk(0, 0, 1, 0), 1, 0, '0);
    add(4'h2, pk(0, 0, 2, 0), 1, 0, '0);
    add(4'h2, pk(0, 0, 3, 0), 1, 0, '0);
    add(4'h2, pk(0, 0, 4, 0), 1, 1, pk(4, 3, 2, 1));
    repeat (2) @(posedge adc_clk);
    #1;
    do_reset();
    foreach (tbl[i]) step(tbl[i].en, tbl[i].bin, tbl[i].bv, tbl[i].push, tbl[i].exp);
    step(4'h2, '0, 0, 0, '0);
    drain();
    for (int i = 1; i <= 3; i++) step(4'h1, pk(0, 0, 0, i), 1, 0, '0);
    do_reset();
    for (int i = 5; i <= 8; i++) step(4'h1, pk(9, 9, 9, i), 1, i == 8, pk(8, 7, 6, 5));
    step(4'h1, '0, 0, 0, '0);
    drain();
    chk("ovf_after_reset", W'(ovf_flag), '0);
    dmac_ovf = 1'b1;
    step(4'h1, '0, 0, 0, '0);
    dmac_ovf = 1'b0;
    step(4'h1, '0, 0, 0, '0);
    chk("ovf_set", W'(ovf_flag), W'(1));
    repeat (3) step(4'h1, '0, 0, 0, '0);
    chk("ovf_sticky", W'(ovf_flag), W'(1));
    do_reset();
    for (int i = 0; i < 5; i++) step(4'hF, pk(i, i + 1, i + 2, i + 3), 1, 1, pk(i, i + 1, i + 2, i + 3));
    step(4'hF, '0, 0, 0, '0);
    drain();
`ifdef MW_ADC_BRIDGE_WORD_COUNT_EN
    chk("word_count", W'(dmac_word_count), W'(5));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
